// File: rtl/nios_cpu_mult_pkg.sv
// Shared definitions for the pipelined Nios multiplier: opcode encodings
// and the lane-count helper used to size the partial-product array.
package nios_cpu_mult_pkg;

    localparam logic [1:0] MUL_OP_MUL = 2'b00;
    localparam logic [1:0] MUL_OP_XSS = 2'b01;
    localparam logic [1:0] MUL_OP_XSU = 2'b10;
    localparam logic [1:0] MUL_OP_XUU = 2'b11;

    function automatic int lane_count(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/nios_cpu_mult_pipe_if.sv
// E-stage issue / M-stage result bundle between the CPU pipeline and the
// multiplier.
interface nios_cpu_mult_pipe_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] E_src1;
    logic [DATA_W-1:0] E_src2;
    logic [1:0]        E_op;
    logic              E_valid;
    logic              M_en;
    logic              flush;
    logic [DATA_W-1:0] M_result;
    logic              M_result_valid;

    modport master (
        output E_src1, E_src2, E_op, E_valid, M_en, flush,
        input  M_result, M_result_valid
    );

    modport slave (
        input  E_src1, E_src2, E_op, E_valid, M_en, flush,
        output M_result, M_result_valid
    );
endinterface

// File: rtl/nios_cpu_mult_lane.sv
// One LANE_W x LANE_W unsigned multiplier with a registered product,
// load enable and asynchronous clear.
module nios_cpu_mult_lane #(
    parameter int LANE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [LANE_W-1:0]     a,
    input  logic [LANE_W-1:0]     b,
    output logic [2*LANE_W-1:0]   p
);
    localparam int PP_W = 2 * LANE_W;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p <= '0;
        end else if (en) begin
            p <= PP_W'(a) * PP_W'(b);
        end
    end
endmodule

// File: rtl/nios_cpu_mult_pipe.sv
// Two-stage DATA_W x DATA_W multiplier: stage 1 registers N*N lane products,
// stage 2 sums them, applies the signed high-half correction and registers the result.
import nios_cpu_mult_pkg::*;

module nios_cpu_mult_pipe #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nios_cpu_mult_pipe_if.slave  bus
);
    localparam int N      = lane_count(DATA_W, LANE_W);
    localparam int PROD_W = 2 * DATA_W;
    localparam int PP_W   = 2 * LANE_W;

    logic [PP_W-1:0]   pp [N*N];
    logic [DATA_W-1:0] a_s1;
    logic [DATA_W-1:0] b_s1;
    logic [1:0]        op_s1;
    logic              sign_a_s1;
    logic              sign_b_s1;
    logic              v1;

    logic [PROD_W-1:0] prod_u;
    logic [DATA_W-1:0] hi_u;
    logic [DATA_W-1:0] hi_s;
    logic [DATA_W-1:0] corr_a;
    logic [DATA_W-1:0] corr_b;
    logic [DATA_W-1:0] result_next;
    logic [DATA_W-1:0] result_q;
    logic              result_valid_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            nios_cpu_mult_lane #(.LANE_W(LANE_W)) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (bus.M_en),
                .a       (bus.E_src1[gi*LANE_W +: LANE_W]),
                .b       (bus.E_src2[gj*LANE_W +: LANE_W]),
                .p       (pp[gi*N+gj])
            );
        end
    end

    // Full operands ride alongside the lane products for the signed correction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_s1      <= '0;
            b_s1      <= '0;
            op_s1     <= MUL_OP_MUL;
            sign_a_s1 <= 1'b0;
            sign_b_s1 <= 1'b0;
        end else if (bus.M_en) begin
            a_s1      <= bus.E_src1;
            b_s1      <= bus.E_src2;
            op_s1     <= bus.E_op;
            sign_a_s1 <= bus.E_src1[DATA_W-1];
            sign_b_s1 <= bus.E_src2[DATA_W-1];
        end
    end

    always_comb begin
        prod_u = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod_u = prod_u + (PROD_W'(pp[i*N+j]) << (LANE_W * (i + j)));
            end
        end
    end

    // Two's-complement fix-up of the unsigned high half; the sA*sB*2^(2W) term wraps away.
    always_comb begin
        hi_u   = prod_u[PROD_W-1:DATA_W];
        corr_a = '0;
        corr_b = '0;
        if (sign_a_s1 && (op_s1 == MUL_OP_XSS || op_s1 == MUL_OP_XSU)) begin
            corr_a = b_s1;
        end
        if (sign_b_s1 && (op_s1 == MUL_OP_XSS)) begin
            corr_b = a_s1;
        end
        hi_s = hi_u - corr_a - corr_b;
        result_next = (op_s1 == MUL_OP_MUL) ? prod_u[DATA_W-1:0] : hi_s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
        end else if (bus.M_en) begin
            result_q <= result_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1             <= 1'b0;
            result_valid_q <= 1'b0;
        end else if (bus.flush) begin
            v1             <= 1'b0;
            result_valid_q <= 1'b0;
        end else if (bus.M_en) begin
            v1             <= bus.E_valid;
            result_valid_q <= v1;
        end
    end

    assign bus.M_result       = result_q;
    assign bus.M_result_valid = result_valid_q;
endmodule

// File: tb/tb_nios_cpu_mult_pipe.sv
// Randomised bench for the pipelined multiplier at DATA_W=32 and DATA_W=64,
// compared every cycle against a transaction-level model using wide arithmetic.
module tb_nios_cpu_mult_pipe;

    localparam logic [63:0] MASK32 = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n;

    logic [63:0] in_a [2];
    logic [63:0] in_b [2];
    logic [1:0]  in_op;
    logic        in_ev;
    logic        in_men;
    logic        in_fl;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    nios_cpu_mult_pipe_if #(.DATA_W(32)) bus32 ();
    nios_cpu_mult_pipe_if #(.DATA_W(64)) bus64 ();

    assign bus32.E_src1  = in_a[0][31:0];
    assign bus32.E_src2  = in_b[0][31:0];
    assign bus32.E_op    = in_op;
    assign bus32.E_valid = in_ev;
    assign bus32.M_en    = in_men;
    assign bus32.flush   = in_fl;
    assign bus64.E_src1  = in_a[1];
    assign bus64.E_src2  = in_b[1];
    assign bus64.E_op    = in_op;
    assign bus64.E_valid = in_ev;
    assign bus64.M_en    = in_men;
    assign bus64.flush   = in_fl;

    nios_cpu_mult_pipe #(.DATA_W(32), .LANE_W(16)) dut32 (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus32)
    );

    nios_cpu_mult_pipe #(.DATA_W(64), .LANE_W(16)) dut64 (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus64)
    );

    // Reference: sign/zero-extend to 128 bits, multiply, pick the requested half.
    function automatic logic [63:0] ref_fn(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] op, input int w);
        logic [127:0] mask, ax, bx, p, res;
        logic sa, sb;
        mask = (128'd1 << w) - 128'd1;
        sa = (op == 2'b01) || (op == 2'b10);
        sb = (op == 2'b01);
        ax = {64'h0, a} & mask;
        bx = {64'h0, b} & mask;
        if (sa && a[w-1]) ax = ax | ~mask;
        if (sb && b[w-1]) bx = bx | ~mask;
        p = ax * bx;
        res = (op == 2'b00) ? p : (p >> w);
        res = res & mask;
        return res[63:0];
    endfunction

    logic [63:0] m_a [2];
    logic [63:0] m_b [2];
    logic [63:0] m_d [2];
    logic [1:0]  m_op;
    logic        m_v1;
    logic        m_ov;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < 2; w++) begin
                m_a[w] <= '0;
                m_b[w] <= '0;
                m_d[w] <= '0;
            end
            m_op <= 2'b00;
            m_v1 <= 1'b0;
            m_ov <= 1'b0;
        end else begin
            if (in_men) begin
                for (int w = 0; w < 2; w++) begin
                    m_d[w] <= ref_fn(m_a[w], m_b[w], m_op, (w == 0) ? 32 : 64);
                    m_a[w] <= in_a[w];
                    m_b[w] <= in_b[w];
                end
                m_op <= in_op;
            end
            if (in_fl) begin
                m_v1 <= 1'b0;
                m_ov <= 1'b0;
            end else if (in_men) begin
                m_v1 <= in_ev;
                m_ov <= m_v1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("res32", {32'h0, bus32.M_result}, m_d[0]);
            check("val32", {63'h0, bus32.M_result_valid}, {63'h0, m_ov});
            check("res64", bus64.M_result, m_d[1]);
            check("val64", {63'h0, bus64.M_result_valid}, {63'h0, m_ov});
        end
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] pick(input logic [63:0] mask);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = (mask == MASK32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
            3: v = 64'd1;
            default: v = rnd64();
        endcase
        return v & mask;
    endfunction

    task automatic drive(input logic [63:0] a32, input logic [63:0] b32,
                         input logic [63:0] a64, input logic [63:0] b64,
                         input logic [1:0] op, input logic ev, input logic men, input logic fl);
        @(negedge clk);
        in_a[0] = a32 & MASK32;
        in_b[0] = b32 & MASK32;
        in_a[1] = a64;
        in_b[1] = b64;
        in_op   = op;
        in_ev   = ev;
        in_men  = men;
        in_fl   = fl;
    endtask

    task automatic idle();
        drive(rnd64(), rnd64(), rnd64(), rnd64(), 2'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b0);
    endtask

    task automatic dir_check(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] op, input logic [31:0] exp);
        drive({32'h0, a}, {32'h0, b}, rnd64(), rnd64(), op, 1'b1, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        check(name, {32'h0, bus32.M_result}, {32'h0, exp});
        check({name, "_v"}, {63'h0, bus32.M_result_valid}, 64'd1);
    endtask

    initial begin
        int new_results;
        logic prev_men;
        logic men;

        rst_n = 1'b1;
        for (int w = 0; w < 2; w++) begin
            in_a[w] = '0;
            in_b[w] = '0;
        end
        in_op  = 2'b00;
        in_ev  = 1'b0;
        in_men = 1'b0;
        in_fl  = 1'b0;
        #1 rst_n = 1'b0;
        #20;
        check("rst_res32", {32'h0, bus32.M_result}, 64'd0);
        check("rst_val32", {63'h0, bus32.M_result_valid}, 64'd0);
        check("rst_res64", bus64.M_result, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        in_men = 1'b1;

        dir_check("mul",    32'h0001_0003, 32'h0002_0005, 2'b00, 32'h000B_000F);
        dir_check("xss_m1", 32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 32'hFFFF_FFFF);
        dir_check("xuu_m1", 32'hFFFF_FFFF, 32'h0000_0002, 2'b11, 32'h0000_0001);
        dir_check("xsu_min", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h8000_0000);
        dir_check("xss_min", 32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000);

        // Four back-to-back ops with a 3-cycle stall once the pipe is full.
        new_results = 0;
        prev_men = 1'b1;
        for (int c = 0; c < 14; c++) begin
            men = !(c >= 5 && c <= 7);
            drive(pick(MASK32), pick(MASK32), pick('1), pick('1),
                  2'($urandom_range(0, 3)), (c < 4), men, 1'b0);
            if (bus32.M_result_valid && prev_men) new_results++;
            prev_men = men;
        end
        check("b2b_count", 64'(new_results), 64'd4);

        // Flush one edge after issue, with a second op arriving alongside the flush.
        idle();
        idle();
        drive(rnd64(), rnd64(), rnd64(), rnd64(), 2'b00, 1'b1, 1'b1, 1'b0);
        drive(rnd64(), rnd64(), rnd64(), rnd64(), 2'b11, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            idle();
            check("flush_v32", {63'h0, bus32.M_result_valid}, 64'd0);
            check("flush_v64", {63'h0, bus64.M_result_valid}, 64'd0);
        end

        // Asynchronous reset between edges with two ops in flight.
        drive(pick(MASK32), pick(MASK32), pick('1), pick('1), 2'b01, 1'b1, 1'b1, 1'b0);
        drive(pick(MASK32), pick(MASK32), pick('1), pick('1), 2'b10, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_res32", {32'h0, bus32.M_result}, 64'd0);
        check("arst_val32", {63'h0, bus32.M_result_valid}, 64'd0);
        check("arst_res64", bus64.M_result, 64'd0);
        check("arst_val64", {63'h0, bus64.M_result_valid}, 64'd0);
        idle();
        idle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idle();
            check("post_rst_v32", {63'h0, bus32.M_result_valid}, 64'd0);
        end

        for (int c = 0; c < 3000; c++) begin
            drive(pick(MASK32), pick(MASK32), pick('1), pick('1),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 19) == 0));
        end
        idle();
        idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
